edsac_btn_conditioner: RTL and testbench

Conditions the raw external push buttons and toggle switches before they reach the EDSAC core. It synchronises every input to the core clock, debounces each one against a shared sample tick, and presents clean levels. It also emits one-cycle press pulses for the Control Switches and change pulses for the Engineer's Control Panel toggles. It sits directly upstream of the `edsac` instance and runs on the same clock as it.

---
 rtl/edsac_btn_pkg.sv | 32 +++
 rtl/edsac_debounce_bit.sv | 58 +++++
 rtl/edsac_btn_conditioner.sv | 112 +++++++++++
 tb/tb_edsac_btn_conditioner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edsac_btn_pkg.sv
// Shared bit map and default widths for the EDSAC button/switch conditioner.
package edsac_btn_pkg;

  localparam int N_PUSH_DEF   = 5;
  localparam int N_TOGGLE_DEF = 18;

  localparam int BTN_RESUME    = 0;
  localparam int BTN_SINGLE_EP = 1;
  localparam int BTN_START     = 2;
  localparam int BTN_STOP      = 3;
  localparam int BTN_EXTENDED  = 4;

  localparam int TGL_O1       = 0;
  localparam int TGL_O2       = 1;
  localparam int TGL_O3       = 2;
  localparam int TGL_O4       = 3;
  localparam int TGL_O5       = 4;
  localparam int TGL_O6       = 5;
  localparam int TGL_O7       = 6;
  localparam int TGL_O8       = 7;
  localparam int TGL_O9       = 8;
  localparam int TGL_O10      = 9;
  localparam int TGL_O11      = 10;
  localparam int TGL_O12      = 11;
  localparam int TGL_O13      = 12;
  localparam int TGL_O14      = 13;
  localparam int TGL_O15      = 14;
  localparam int TGL_O16      = 15;
  localparam int TGL_O17      = 16;
  localparam int TGL_ENG_MODE = 17;

endpackage

// File: rtl/edsac_debounce_bit.sv
// One input: 2-FF synchroniser, tick-sampled history and hysteretic level
// register. rise/fall are strobes for the edge on which level changes.
module edsac_debounce_bit
  import edsac_btn_pkg::*;
#(
  parameter int STABLE_SAMPLES = 8,
  parameter bit INVERT         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  input  logic update,
  input  logic load,
  output logic level,
  output logic rise,
  output logic fall
);

  logic                      sync_1;
  logic                      sync_2;
  logic                      sync_val;
  logic [STABLE_SAMPLES-2:0] hist;
  logic [STABLE_SAMPLES-1:0] window;
  logic                      all_one;
  logic                      all_zero;

  assign sync_val = INVERT ? ~sync_2 : sync_2;
  // Only the newest S-1 samples plus the live synchronised value decide.
  assign window   = {hist, sync_val};
  assign all_one  = &window;
  assign all_zero = ~|window;
  assign rise     = update & all_one  & ~level;
  assign fall     = update & all_zero &  level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      hist   <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (tick) begin
        hist <= window[STABLE_SAMPLES-2:0];
      end
      if (load) begin
        level <= all_one;
      end else if (rise) begin
        level <= 1'b1;
      end else if (fall) begin
        level <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/edsac_btn_conditioner.sv
// Conditions EDSAC control-panel buttons and toggles: synchronise, debounce
// on a shared sample tick, and emit press/change pulses after startup.
module edsac_btn_conditioner
  import edsac_btn_pkg::*;
#(
  parameter int N_PUSH          = N_PUSH_DEF,
  parameter int N_TOGGLE        = N_TOGGLE_DEF,
  parameter int TICK_DIV        = 250,
  parameter int STABLE_SAMPLES  = 8,
  parameter bit PUSH_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_PUSH-1:0]   push_raw,
  input  logic [N_TOGGLE-1:0] toggle_raw,
  output logic [N_PUSH-1:0]   push_level,
  output logic [N_PUSH-1:0]   push_pulse,
  output logic [N_TOGGLE-1:0] toggle_level,
  output logic [N_TOGGLE-1:0] toggle_changed,
  output logic                ready
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int INH_W = $clog2(STABLE_SAMPLES + 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic [INH_W-1:0]    inh_cnt;
  logic                tick;
  logic                update;
  logic                load;
  logic [N_PUSH-1:0]   push_rise;
  logic [N_PUSH-1:0]   push_fall;
  logic [N_PUSH-1:0]   push_ev;
  logic [N_TOGGLE-1:0] tgl_rise;
  logic [N_TOGGLE-1:0] tgl_fall;

  assign tick   = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign update = tick & ready;
  // The final startup tick seeds every level from its window, pulse-free.
  assign load   = tick & ~ready & (inh_cnt == INH_W'(STABLE_SAMPLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      inh_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick && (inh_cnt != INH_W'(STABLE_SAMPLES))) begin
        inh_cnt <= inh_cnt + 1'b1;
      end
      if (load) begin
        ready <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_PUSH; i++) begin : gen_push
    edsac_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .INVERT        (PUSH_ACTIVE_LOW)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (push_raw[i]),
      .tick  (tick),
      .update(update),
      .load  (load),
      .level (push_level[i]),
      .rise  (push_rise[i]),
      .fall  (push_fall[i])
    );
  end

  for (genvar i = 0; i < N_TOGGLE; i++) begin : gen_tgl
    edsac_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .INVERT        (1'b0)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (toggle_raw[i]),
      .tick  (tick),
      .update(update),
      .load  (load),
      .level (toggle_level[i]),
      .rise  (tgl_rise[i]),
      .fall  (tgl_fall[i])
    );
  end

  // Stop wins over resume/single_ep/start on the same edge; extended is independent.
  always_comb begin
    push_ev = push_rise & ~push_fall;
    if (push_ev[BTN_STOP]) begin
      push_ev[BTN_RESUME]    = 1'b0;
      push_ev[BTN_SINGLE_EP] = 1'b0;
      push_ev[BTN_START]     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_pulse     <= '0;
      toggle_changed <= '0;
    end else begin
      push_pulse     <= push_ev;
      toggle_changed <= tgl_rise | tgl_fall;
    end
  end

endmodule

// File: tb/tb_edsac_btn_conditioner.sv
// Directed bench for edsac_btn_conditioner with TICK_DIV=4, STABLE_SAMPLES=3.
module tb_edsac_btn_conditioner;

  localparam int NP = 5;
  localparam int NT = 18;
  localparam int TD = 4;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] push_raw = '0;
  logic [NT-1:0] toggle_raw = '0;
  logic [NP-1:0] push_level;
  logic [NP-1:0] push_pulse;
  logic [NT-1:0] toggle_level;
  logic [NT-1:0] toggle_changed;
  logic          ready;

  int checks = 0;
  int errors = 0;
  int cyc;
  int pp_cnt [NP] = '{default: 0};
  int tc_cnt [NT] = '{default: 0};
  int lv2_cnt = 0;
  int pp_base [NP];
  int tc_base [NT];
  int lv2_base;
  int e;
  int at;
  int dsum;

  edsac_btn_conditioner #(
    .N_PUSH         (NP),
    .N_TOGGLE       (NT),
    .TICK_DIV       (TD),
    .STABLE_SAMPLES (SS),
    .PUSH_ACTIVE_LOW(1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_raw      (push_raw),
    .toggle_raw    (toggle_raw),
    .push_level    (push_level),
    .push_pulse    (push_pulse),
    .toggle_level  (toggle_level),
    .toggle_changed(toggle_changed),
    .ready         (ready)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // pulse and level monitors, sampled away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) pp_cnt[i] <= pp_cnt[i] + int'(push_pulse[i]);
    for (int i = 0; i < NT; i++) tc_cnt[i] <= tc_cnt[i] + int'(toggle_changed[i]);
    lv2_cnt <= lv2_cnt + int'(push_level[2]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edge on which a level changes after a raw change made just after edge ev.
  function automatic int exp_edge(input int ev);
    int t1;
    t1 = ((ev + 3 + TD - 1) / TD) * TD;
    return t1 + (SS - 1) * TD;
  endfunction

  task automatic wait_push(input int b, input logic v, input int budget, output int when);
    bit found = 0;
    when = -1;
    for (int k = 0; k < budget && !found; k++) begin
      step(1);
      if (push_level[b] === v) begin
        found = 1;
        when  = cyc;
      end
    end
  endtask

  task automatic snap();
    pp_base  = pp_cnt;
    tc_base  = tc_cnt;
    lv2_base = lv2_cnt;
  endtask

  task automatic pulse_total(output int s);
    s = 0;
    for (int i = 0; i < NP; i++) s += pp_cnt[i] - pp_base[i];
    for (int i = 0; i < NT; i++) s += tc_cnt[i] - tc_base[i];
  endtask

  initial begin
    // reset state
    snap();
    step(3);
    chk("rst_ready", ready, 0);
    chk("rst_push_level", push_level, 0);
    chk("rst_push_pulse", push_pulse, 0);
    chk("rst_toggle_level", toggle_level, 0);
    chk("rst_toggle_changed", toggle_changed, 0);
    rst_n = 1'b1;
    step(SS * TD - 1);
    chk("ready_before", ready, 0);
    step(1);
    chk("ready_at_12", ready, 1);
    chk("ready_levels", {push_level, toggle_level}, 0);
    step(1);
    pulse_total(dsum);
    chk("startup_no_pulse", dsum, 0);

    // clean press and release of start
    snap();
    push_raw[2] = 1'b1;
    e = cyc;
    wait_push(2, 1'b1, 30, at);
    chk("press_latency", at, exp_edge(e));
    chk("press_latency_min", (at - e) >= 11, 1);
    chk("press_latency_max", (at - e) <= 14, 1);
    chk("press_pulse", push_pulse, 5'b00100);
    step(1);
    chk("press_pulse_width", push_pulse, 0);
    chk("press_level_held", push_level, 5'b00100);
    step(40 - (at - e) - 1);
    push_raw[2] = 1'b0;
    e = cyc;
    wait_push(2, 1'b0, 30, at);
    chk("release_latency", at, exp_edge(e));
    chk("release_no_pulse", push_pulse, 0);
    step(2);
    chk("press_pulse_count", pp_cnt[2] - pp_base[2], 1);

    // bounce rejection
    snap();
    for (int k = 0; k < 10; k++) begin
      push_raw[2] = ~push_raw[2];
      step(3);
    end
    push_raw[2] = 1'b0;
    step(30);
    chk("bounce_level_cycles", lv2_cnt - lv2_base, 0);
    chk("bounce_pulses", pp_cnt[2] - pp_base[2], 0);
    chk("bounce_level_end", push_level, 0);

    // stop priority over start
    snap();
    push_raw[3:2] = 2'b11;
    e = cyc;
    wait_push(3, 1'b1, 30, at);
    chk("stop_latency", at, exp_edge(e));
    chk("stop_pulse_only", push_pulse, 5'b01000);
    chk("stop_levels", push_level, 5'b01100);
    step(2);
    chk("stop_pulse_count", pp_cnt[3] - pp_base[3], 1);
    chk("start_dropped", pp_cnt[2] - pp_base[2], 0);
    push_raw[3:2] = 2'b00;
    wait_push(3, 1'b0, 30, at);
    chk("stop_release_seen", at != -1, 1);
    step(2);
    chk("stop_release_levels", push_level, 0);

    // o5 and resume held through reset
    push_raw[0]   = 1'b1;
    toggle_raw[4] = 1'b1;
    step(2);
    snap();
    rst_n = 1'b0;
    step(3);
    chk("held_rst_levels", {push_level, toggle_level}, 0);
    rst_n = 1'b1;
    step(SS * TD - 1);
    chk("held_ready_before", ready, 0);
    chk("held_level_before", push_level, 0);
    step(1);
    chk("held_ready", ready, 1);
    chk("held_push_level", push_level, 5'b00001);
    chk("held_toggle_level", toggle_level, 18'h00010);
    step(3);
    pulse_total(dsum);
    chk("held_no_pulses", dsum, 0);

    // async reset mid-debounce of o8
    snap();
    toggle_raw[7] = 1'b1;
    step(8);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_ready", ready, 0);
    chk("async_levels", {push_level, toggle_level}, 0);
    chk("async_pulses", {push_pulse, toggle_changed}, 0);
    step(1);
    rst_n = 1'b1;
    step(SS * TD);
    chk("async_ready_again", ready, 1);
    chk("async_toggle_level", toggle_level, 18'h00090);
    chk("async_push_level", push_level, 5'b00001);
    step(3);
    pulse_total(dsum);
    chk("async_no_pulses", dsum, 0);

    // toggle change pulse on o8 release
    snap();
    toggle_raw[7] = 1'b0;
    e = cyc;
    at = -1;
    for (int k = 0; k < 30 && at == -1; k++) begin
      step(1);
      if (toggle_level[7] === 1'b0) at = cyc;
    end
    chk("toggle_latency", at, exp_edge(e));
    chk("toggle_changed", toggle_changed, 18'h00080);
    step(1);
    chk("toggle_changed_width", toggle_changed, 0);
    step(1);
    chk("toggle_changed_count", tc_cnt[7] - tc_base[7], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
